mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares the single data-memory/cache port between the instruction-fetch requester and the memory-access stage requester. Fixed priority goes to the data requester, with at most one outstanding transaction. Sits between the fetch unit / memory-access stage and the memory port. Generates per-requester stall and return-valid signals so each pipeline stage holds until its transaction completes.

Parameters:
XLEN, 32, address/data width
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (used only with the optional feature)

Ports:
clock_i  in  1  clock
nreset_i  in  1  asynchronous active-low reset
if_req_i  in  1  fetch request; held with address until if_rvalid_o
if_addr_i  in  XLEN  fetch address
if_stall_o  out  1  fetch must hold
if_rvalid_o  out  1  fetch data valid, 1-cycle pulse
if_rdata_o  out  XLEN  fetch read data
d_req_i  in  1  data request; held with all fields until d_rvalid_o
d_addr_i  in  XLEN  data address
d_wdata_i  in  XLEN  store data
d_size_i  in  2  0=byte, 1=half, 2=word
d_wen_i  in  1  1=store, 0=load
d_stall_o  out  1  data stage must hold
d_rvalid_o  out  1  load data valid / store acknowledge, 1-cycle pulse
d_rdata_o  out  XLEN  load data
mem_req_o  out  1  request to memory port
mem_addr_o  out  XLEN  memory address
mem_wdata_o  out  XLEN  memory write data
mem_size_o  out  2  access size
mem_wen_o  out  1  write enable
mem_gnt_i  in  1  memory accepts request this cycle
mem_rvalid_i  in  1  response valid (read data or write ack)
mem_rdata_i  in  XLEN  response data

Behaviour:
- Clock is clock_i; reset is nreset_i, asynchronous and active-low.
- FSM states: IDLE, WAIT_D, WAIT_I. Reset puts the FSM in IDLE, clears the owner and starvation counter, and drives if_rvalid_o=0, d_rvalid_o=0, if_rdata_o=0, d_rdata_o=0.
- IDLE: winner is d_req_i if set, else if_req_i.
  - mem_req_o=1 combinationally with the winner's fields.
  - Fetch requests drive mem_wen_o=0 and mem_size_o=2.
  - If no request: mem_req_o=0 and all other mem_* outputs are 0.
- IDLE + mem_gnt_i=1: go to WAIT_D or WAIT_I according to the winner. Without a grant, stay in IDLE and re-arbitrate next cycle; a newly arriving d_req_i may pre-empt an ungranted fetch.
- WAIT_x: mem_req_o=0. On mem_rvalid_i:
  - Register mem_rdata_i into the owner's rdata_o.
  - Pulse the owner's rvalid_o for exactly the next cycle.
  - Return to IDLE.
- Minimum latency: grant at cycle N, rvalid at N+1 or later, requester rvalid_o at rvalid+1.
- In the cycle rvalid_o is high the FSM is IDLE and may already present the next request (back-to-back is allowed).
- Non-owner rdata_o holds its previous value.
- Stalls: x_stall_o = x_req_i & ~x_rvalid_o (combinational). The non-owner stays stalled throughout.
- mem_rvalid_i in IDLE (stray or late after reset) is ignored.
- mem_gnt_i outside IDLE is ignored.
- Reset asserted mid-transaction: the outstanding transaction is abandoned and no rvalid is delivered.
- Both requests arriving in the same cycle: data wins; fetch stays stalled.

Optional Feature:
ARB_STARVE_GUARD_EN.
- Defined: a saturating counter increments on each data grant made while if_req_i=1, and clears on any fetch grant. When the counter equals STARVE_LIMIT, the next IDLE arbitration grants fetch even if d_req_i=1.
- Undefined: pure fixed priority and no counter logic; fetch may starve indefinitely.

Test Plan:
1. Fetch only: if_req_i=1, addr=0x100, gnt same cycle, rvalid 2 cycles later with rdata=0xDEADBEEF -> mem_req_o=1 for 1 cycle; if_rvalid_o pulses 1 cycle with if_rdata_o=0xDEADBEEF; if_stall_o drops in that cycle.
2. Simultaneous requests: if_req_i=1, d_req_i=1 (store, addr=0x2000, wdata=0x55, size=0) -> first grant is data with mem_wen_o=1, mem_size_o=0, mem_wdata_o=0x55; fetch is issued in the cycle d_rvalid_o pulses.
3. Delayed grant: mem_gnt_i low 3 cycles -> mem_req_o stays 1 with stable fields; both stalls stay high; FSM stays IDLE.
4. Reset mid-wait: nreset_i low while in WAIT_D, then rvalid arrives after release -> no d_rvalid_o, FSM IDLE, all outputs at reset values.
5. Starvation (macro defined, STARVE_LIMIT=4): continuous d_req_i with if_req_i=1 -> fifth grant goes to fetch; with macro undefined, fetch is never granted.
6. Stray mem_rvalid_i=1 in IDLE with rdata=0x1234 -> no rvalid pulse and no rdata_o change.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory-port and response signals for mem_port_arbiter.
// master drives requests and memory responses; slave is the arbiter side.
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            if_req_i;
  logic [XLEN-1:0] if_addr_i;
  logic            if_stall_o;
  logic            if_rvalid_o;
  logic [XLEN-1:0] if_rdata_o;
  logic            d_req_i;
  logic [XLEN-1:0] d_addr_i;
  logic [XLEN-1:0] d_wdata_i;
  logic [1:0]      d_size_i;
  logic            d_wen_i;
  logic            d_stall_o;
  logic            d_rvalid_o;
  logic [XLEN-1:0] d_rdata_o;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [1:0]      mem_size_o;
  logic            mem_wen_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_addr_i, d_wdata_i,
    output d_size_i, d_wen_i,
    output mem_gnt_i, mem_rvalid_i,
    output mem_rdata_i,
    input  if_stall_o, if_rvalid_o,
    input  if_rdata_o,
    input  d_stall_o, d_rvalid_o, d_rdata_o,
    input  mem_req_o, mem_addr_o,
    input  mem_wdata_o, mem_size_o,
    input  mem_wen_o
  );

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_addr_i, d_wdata_i,
    input  d_size_i, d_wen_i,
    input  mem_gnt_i, mem_rvalid_i,
    input  mem_rdata_i,
    output if_stall_o, if_rvalid_o,
    output if_rdata_o,
    output d_stall_o, d_rvalid_o, d_rdata_o,
    output mem_req_o, mem_addr_o,
    output mem_wdata_o, mem_size_o,
    output mem_wen_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters; data has
// fixed priority, one outstanding transaction, per-requester stall and
// rvalid. Ports: clock_i, nreset_i (async low), bus (slave modport).
// Optional macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT data grants
// made while fetch waits, the next arbitration goes to fetch.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clock_i,
  input logic               nreset_i,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_D = 2'd1,
    WAIT_I = 2'd2
  } state_t;

  state_t          state;
  logic            if_rvalid_q;
  logic            d_rvalid_q;
  logic [XLEN-1:0] if_rdata_q;
  logic [XLEN-1:0] d_rdata_q;

  logic is_idle;
  logic force_i;
  logic pick_d;
  logic pick_i;

  assign is_idle = (state == IDLE);

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  // Fetch is only forced when it is actually waiting.
  assign force_i = bus.if_req_i &
                   (starve_cnt == LIM);

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      starve_cnt <= '0;
    end else if (is_idle && bus.mem_gnt_i) begin
      if (pick_i) begin
        starve_cnt <= '0;
      end else if (pick_d && bus.if_req_i &&
                   starve_cnt != LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign force_i = 1'b0;
`endif

  assign pick_d = is_idle & bus.d_req_i & ~force_i;
  assign pick_i = is_idle & bus.if_req_i & ~pick_d;

  // Request fields go out combinationally while IDLE only.
  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_size_o  = 2'd0;
    bus.mem_wen_o   = 1'b0;
    unique case (1'b1)
      pick_d: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_addr_o  = bus.d_addr_i;
        bus.mem_wdata_o = bus.d_wdata_i;
        bus.mem_size_o  = bus.d_size_i;
        bus.mem_wen_o   = bus.d_wen_i;
      end
      pick_i: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = bus.if_addr_i;
        bus.mem_size_o = 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state       <= IDLE;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.mem_gnt_i && pick_d) begin
            state <= WAIT_D;
          end else if (bus.mem_gnt_i && pick_i) begin
            state <= WAIT_I;
          end
        end
        WAIT_D: begin
          if (bus.mem_rvalid_i) begin
            d_rdata_q  <= bus.mem_rdata_i;
            d_rvalid_q <= 1'b1;
            state      <= IDLE;
          end
        end
        WAIT_I: begin
          if (bus.mem_rvalid_i) begin
            if_rdata_q  <= bus.mem_rdata_i;
            if_rvalid_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.d_rvalid_o  = d_rvalid_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.if_stall_o  = bus.if_req_i & ~if_rvalid_q;
  assign bus.d_stall_o   = bus.d_req_i & ~d_rvalid_q;

endmodule
